// File: rtl/prg_mem.sv
// -----------------------------------------------------------------------------
// prg_mem : reloadable program memory feeding a small CPU fetch stage.
//
// After reset, or on a load request, the whole memory is first overwritten
// with FILL (one word per cycle, ascending). A streamed program is then
// accepted word by word from address 0 upward until LD_LAST or the top address.
// Instruction fetches are served only while idle, with one cycle of latency.
//
// Ports
//   CLK       in   rising-edge clock
//   RST       in   asynchronous active-high reset
//   PCNT      in   fetch address (program counter)
//   FETCH_EN  in   fetch request
//   MC_CODE   out  registered machine-code word
//   MC_VALID  out  MC_CODE holds the word fetched on the previous edge
//   LD_START  in   request to clear and reload the memory (honoured when idle)
//   LD_DATA   in   load word
//   LD_VALID  in   LD_DATA valid
//   LD_LAST   in   marks the final load word
//   LD_READY  out  a load word is accepted this cycle when LD_VALID is high
//   LD_DONE   out  one-cycle pulse after the final word is written
//   LD_CNT    out  number of words written by the most recent load
//   BUSY      out  clearing or loading
// -----------------------------------------------------------------------------
module prg_mem #(
  parameter int                ADDR_W = 4,
  parameter int                DATA_W = 8,
  parameter logic [DATA_W-1:0] FILL   = 8'hDF
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [ADDR_W-1:0] PCNT,
  input  logic              FETCH_EN,
  output logic [DATA_W-1:0] MC_CODE,
  output logic              MC_VALID,
  input  logic              LD_START,
  input  logic [DATA_W-1:0] LD_DATA,
  input  logic              LD_VALID,
  input  logic              LD_LAST,
  output logic              LD_READY,
  output logic              LD_DONE,
  output logic [ADDR_W:0]   LD_CNT,
  output logic              BUSY
);

  localparam int DEPTH = 1 << ADDR_W;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] CLEAR = 2'd1;
  localparam logic [1:0] LOAD  = 2'd2;

  localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0] code_q, code_d;
  logic              valid_q, valid_d;
  logic              done_q, done_d;

  logic              mem_we;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_q [DEPTH];

  // Next-state, write-port and fetch-path logic.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    code_d    = code_q;
    valid_d   = 1'b0;
    done_d    = 1'b0;
    mem_we    = 1'b0;
    mem_wdata = FILL;
    case (state_q)
      IDLE: begin
        // A load request wins over a fetch issued in the same cycle.
        if (LD_START) begin
          state_d = CLEAR;
          ptr_d   = '0;
          cnt_d   = '0;
          code_d  = FILL;
        end else if (FETCH_EN) begin
          code_d  = mem_q[PCNT];
          valid_d = 1'b1;
        end else begin
          code_d  = code_q;
        end
      end
      CLEAR: begin
        mem_we    = 1'b1;
        mem_wdata = FILL;
        code_d    = FILL;
        if (ptr_q == LAST_ADDR) begin
          state_d = LOAD;
          ptr_d   = '0;
          cnt_d   = '0;
        end else begin
          ptr_d   = ptr_q + 1'b1;
        end
      end
      LOAD: begin
        code_d = FILL;
        if (LD_VALID) begin
          mem_we    = 1'b1;
          mem_wdata = LD_DATA;
          cnt_d     = cnt_q + 1'b1;
          // The top address ends the load even without LD_LAST: no wrap to 0.
          if (LD_LAST || (ptr_q == LAST_ADDR)) begin
            state_d = IDLE;
            ptr_d   = '0;
            done_d  = 1'b1;
          end else begin
            ptr_d   = ptr_q + 1'b1;
          end
        end else begin
          ptr_d = ptr_q;
        end
      end
      default: begin
        state_d = CLEAR;
        ptr_d   = '0;
        cnt_d   = '0;
        code_d  = FILL;
      end
    endcase
  end

  // Control and output registers; reset restarts the clear sweep at once.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= CLEAR;
      ptr_q   <= '0;
      cnt_q   <= '0;
      code_q  <= FILL;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      code_q  <= code_d;
      valid_q <= valid_d;
      done_q  <= done_d;
    end
  end

  // Storage array; contents are defined by the clear sweep, not by reset.
  always_ff @(posedge CLK) begin
    if (mem_we) begin
      mem_q[ptr_q] <= mem_wdata;
    end
  end

  assign MC_CODE  = code_q;
  assign MC_VALID = valid_q;
  assign LD_READY = (state_q == LOAD);
  assign LD_DONE  = done_q;
  assign LD_CNT   = cnt_q;
  assign BUSY     = (state_q != IDLE);

endmodule

// File: tb/tb_prg_mem.sv
module tb_prg_mem;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic [3:0] PCNT = 4'd0;
  logic       FETCH_EN = 1'b0;
  logic [7:0] MC_CODE;
  logic       MC_VALID;
  logic       LD_START = 1'b0;
  logic [7:0] LD_DATA = 8'd0;
  logic       LD_VALID = 1'b0;
  logic       LD_LAST = 1'b0;
  logic       LD_READY;
  logic       LD_DONE;
  logic [4:0] LD_CNT;
  logic       BUSY;

  int errors = 0;
  int checks = 0;

  prg_mem #(.ADDR_W(4), .DATA_W(8), .FILL(8'hDF)) dut (
    .CLK(CLK), .RST(RST), .PCNT(PCNT), .FETCH_EN(FETCH_EN),
    .MC_CODE(MC_CODE), .MC_VALID(MC_VALID), .LD_START(LD_START),
    .LD_DATA(LD_DATA), .LD_VALID(LD_VALID), .LD_LAST(LD_LAST),
    .LD_READY(LD_READY), .LD_DONE(LD_DONE), .LD_CNT(LD_CNT), .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic send(input logic [7:0] d, input logic last);
    LD_DATA = d; LD_LAST = last; LD_VALID = 1'b1;
    tick();
    LD_VALID = 1'b0; LD_LAST = 1'b0;
  endtask

  task automatic fetch(input logic [3:0] a);
    PCNT = a; FETCH_EN = 1'b1;
    tick();
    FETCH_EN = 1'b0;
  endtask

  task automatic start_load;
    LD_START = 1'b1;
    tick();
    LD_START = 1'b0;
  endtask

  task automatic wait_ready(input int budget);
    int n = 0;
    while (LD_READY !== 1'b1 && n < budget) begin tick(); n++; end
    checks++; if (LD_READY !== 1'b1) begin errors++; $display("FAIL wait_ready: got %b expected 1 within %0d cycles", LD_READY, budget); end
  endtask

  task automatic test_reset;
    #3 RST = 1'b1;
    #1;
    checks++; if (BUSY !== 1'b1) begin errors++; $display("FAIL rst_busy: got %b expected 1", BUSY); end
    checks++; if (LD_READY !== 1'b0) begin errors++; $display("FAIL rst_ready: got %b expected 0", LD_READY); end
    checks++; if (LD_DONE !== 1'b0) begin errors++; $display("FAIL rst_done: got %b expected 0", LD_DONE); end
    checks++; if (LD_CNT !== 5'd0) begin errors++; $display("FAIL rst_cnt: got %0d expected 0", LD_CNT); end
    checks++; if (MC_VALID !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b expected 0", MC_VALID); end
    checks++; if (MC_CODE !== 8'hDF) begin errors++; $display("FAIL rst_code: got %h expected df", MC_CODE); end
    @(negedge CLK);
    RST = 1'b0;
    // Cycles 1..16 after release are the clear sweep.
    for (int i = 1; i <= 16; i++) begin
      checks++; if (BUSY !== 1'b1 || LD_READY !== 1'b0) begin errors++; $display("FAIL clear_cycle%0d: got busy=%b ready=%b expected busy=1 ready=0", i, BUSY, LD_READY); end
      tick();
    end
    checks++; if (LD_READY !== 1'b1 || BUSY !== 1'b1) begin errors++; $display("FAIL ready_cycle17: got ready=%b busy=%b expected 1 1", LD_READY, BUSY); end
    // Fetch requests during LOAD are ignored.
    FETCH_EN = 1'b1; PCNT = 4'd0;
    tick();
    FETCH_EN = 1'b0;
    checks++; if (MC_VALID !== 1'b0 || MC_CODE !== 8'hDF) begin errors++; $display("FAIL load_fetch: got valid=%b code=%h expected 0 df", MC_VALID, MC_CODE); end
    checks++; if (LD_READY !== 1'b1 || LD_CNT !== 5'd0) begin errors++; $display("FAIL load_idle: got ready=%b cnt=%0d expected 1 0", LD_READY, LD_CNT); end
  endtask

  task automatic test_basic_load;
    logic [7:0] exp [4] = '{8'h90, 8'h4E, 8'hD0, 8'hDF};
    send(8'h90, 1'b0);
    checks++; if (LD_DONE !== 1'b0 || LD_CNT !== 5'd1) begin errors++; $display("FAIL basic_w1: got done=%b cnt=%0d expected 0 1", LD_DONE, LD_CNT); end
    send(8'h4E, 1'b0);
    send(8'hD0, 1'b1);
    checks++; if (LD_DONE !== 1'b1) begin errors++; $display("FAIL basic_done: got %b expected 1", LD_DONE); end
    checks++; if (LD_CNT !== 5'd3 || BUSY !== 1'b0 || LD_READY !== 1'b0) begin errors++; $display("FAIL basic_end: got cnt=%0d busy=%b ready=%b expected 3 0 0", LD_CNT, BUSY, LD_READY); end
    tick();
    checks++; if (LD_DONE !== 1'b0 || LD_CNT !== 5'd3) begin errors++; $display("FAIL basic_pulse: got done=%b cnt=%0d expected 0 3", LD_DONE, LD_CNT); end
    for (int a = 0; a < 4; a++) begin
      fetch(4'(a));
      checks++; if (MC_CODE !== exp[a] || MC_VALID !== 1'b1) begin errors++; $display("FAIL basic_fetch%0d: got code=%h valid=%b expected %h 1", a, MC_CODE, MC_VALID, exp[a]); end
    end
    tick();
    checks++; if (MC_VALID !== 1'b0 || MC_CODE !== 8'hDF) begin errors++; $display("FAIL basic_hold: got valid=%b code=%h expected 0 df", MC_VALID, MC_CODE); end
  endtask

  task automatic test_full_load;
    start_load();
    checks++; if (BUSY !== 1'b1 || LD_CNT !== 5'd0 || MC_VALID !== 1'b0) begin errors++; $display("FAIL full_start: got busy=%b cnt=%0d valid=%b expected 1 0 0", BUSY, LD_CNT, MC_VALID); end
    wait_ready(20);
    for (int i = 0; i < 16; i++) begin
      send(8'(i), 1'b0);
      if (i == 14) begin
        checks++; if (LD_DONE !== 1'b0 || LD_READY !== 1'b1) begin errors++; $display("FAIL full_w15: got done=%b ready=%b expected 0 1", LD_DONE, LD_READY); end
      end
    end
    checks++; if (LD_DONE !== 1'b1 || LD_READY !== 1'b0 || BUSY !== 1'b0) begin errors++; $display("FAIL full_done: got done=%b ready=%b busy=%b expected 1 0 0", LD_DONE, LD_READY, BUSY); end
    checks++; if (LD_CNT !== 5'd16) begin errors++; $display("FAIL full_cnt: got %0d expected 16", LD_CNT); end
    send(8'hEE, 1'b0);
    checks++; if (LD_CNT !== 5'd16 || LD_DONE !== 1'b0 || BUSY !== 1'b0) begin errors++; $display("FAIL full_17th: got cnt=%0d done=%b busy=%b expected 16 0 0", LD_CNT, LD_DONE, BUSY); end
    fetch(4'd0);
    checks++; if (MC_CODE !== 8'h00 || MC_VALID !== 1'b1) begin errors++; $display("FAIL full_addr0: got %h valid=%b expected 00 1", MC_CODE, MC_VALID); end
    fetch(4'd7);
    checks++; if (MC_CODE !== 8'h07) begin errors++; $display("FAIL full_addr7: got %h expected 07", MC_CODE); end
    fetch(4'd15);
    checks++; if (MC_CODE !== 8'h0F) begin errors++; $display("FAIL full_addr15: got %h expected 0f", MC_CODE); end
  endtask

  task automatic test_stall;
    int accepted = 0;
    logic [7:0] exp [5] = '{8'hC0, 8'hC2, 8'hC4, 8'hC6, 8'hDF};
    start_load();
    wait_ready(20);
    for (int i = 0; i < 8; i++) begin
      LD_DATA  = 8'hC0 + 8'(i);
      LD_VALID = (i % 2 == 0);
      LD_LAST  = (i == 6);
      LD_START = (i == 3); // must be ignored while loading
      if (i % 2 == 0 && i <= 6) accepted++;
      tick();
      LD_VALID = 1'b0; LD_LAST = 1'b0; LD_START = 1'b0;
      checks++; if (LD_CNT !== 5'(accepted)) begin errors++; $display("FAIL stall_cnt%0d: got %0d expected %0d", i, LD_CNT, accepted); end
      checks++; if (LD_READY !== (i < 6) || LD_DONE !== (i == 6)) begin errors++; $display("FAIL stall_ctl%0d: got ready=%b done=%b expected %b %b", i, LD_READY, LD_DONE, (i < 6), (i == 6)); end
    end
    for (int a = 0; a < 5; a++) begin
      fetch(4'(a));
      checks++; if (MC_CODE !== exp[a]) begin errors++; $display("FAIL stall_fetch%0d: got %h expected %h", a, MC_CODE, exp[a]); end
    end
  endtask

  task automatic test_reset_mid_load;
    start_load();
    wait_ready(20);
    send(8'h55, 1'b0);
    send(8'h66, 1'b0);
    checks++; if (LD_CNT !== 5'd2) begin errors++; $display("FAIL abort_pre: got cnt=%0d expected 2", LD_CNT); end
    #2 RST = 1'b1;
    #1;
    checks++; if (BUSY !== 1'b1 || LD_READY !== 1'b0 || LD_CNT !== 5'd0 || LD_DONE !== 1'b0) begin errors++; $display("FAIL abort_rst: got busy=%b ready=%b cnt=%0d done=%b expected 1 0 0 0", BUSY, LD_READY, LD_CNT, LD_DONE); end
    @(negedge CLK);
    RST = 1'b0;
    wait_ready(20);
    send(8'hA1, 1'b1);
    checks++; if (LD_DONE !== 1'b1 || LD_CNT !== 5'd1) begin errors++; $display("FAIL abort_done: got done=%b cnt=%0d expected 1 1", LD_DONE, LD_CNT); end
    fetch(4'd0);
    checks++; if (MC_CODE !== 8'hA1) begin errors++; $display("FAIL abort_addr0: got %h expected a1", MC_CODE); end
    fetch(4'd1);
    checks++; if (MC_CODE !== 8'hDF) begin errors++; $display("FAIL abort_addr1: got %h expected df", MC_CODE); end
    fetch(4'd2);
    checks++; if (MC_CODE !== 8'hDF) begin errors++; $display("FAIL abort_addr2: got %h expected df", MC_CODE); end
  endtask

  task automatic test_start_fetch;
    LD_START = 1'b1; FETCH_EN = 1'b1; PCNT = 4'd0;
    tick();
    LD_START = 1'b0;
    checks++; if (BUSY !== 1'b1 || MC_VALID !== 1'b0 || MC_CODE !== 8'hDF || LD_CNT !== 5'd0) begin errors++; $display("FAIL sf_start: got busy=%b valid=%b code=%h cnt=%0d expected 1 0 df 0", BUSY, MC_VALID, MC_CODE, LD_CNT); end
    tick();
    checks++; if (MC_VALID !== 1'b0 || MC_CODE !== 8'hDF) begin errors++; $display("FAIL sf_clear_fetch: got valid=%b code=%h expected 0 df", MC_VALID, MC_CODE); end
    FETCH_EN = 1'b0;
    wait_ready(20);
    send(8'h3C, 1'b1);
    checks++; if (LD_DONE !== 1'b1 || LD_CNT !== 5'd1) begin errors++; $display("FAIL sf_done: got done=%b cnt=%0d expected 1 1", LD_DONE, LD_CNT); end
    tick();
    checks++; if (LD_DONE !== 1'b0) begin errors++; $display("FAIL sf_pulse: got %b expected 0", LD_DONE); end
    fetch(4'd0);
    checks++; if (MC_CODE !== 8'h3C || MC_VALID !== 1'b1) begin errors++; $display("FAIL sf_addr0: got %h valid=%b expected 3c 1", MC_CODE, MC_VALID); end
    fetch(4'd1);
    checks++; if (MC_CODE !== 8'hDF) begin errors++; $display("FAIL sf_addr1: got %h expected df", MC_CODE); end
  endtask

  initial begin
    test_reset();
    test_basic_load();
    test_full_load();
    test_stall();
    test_reset_mid_load();
    test_start_fetch();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/prg_mem.md
PRG_MEM -- requirements
Module: prg_mem

Parameters
REQ-001 SHALL provide parameter ADDR_W, default 4, program-counter width; depth DEPTH = 2^ADDR_W words.
REQ-002 SHALL provide parameter DATA_W, default 8, machine-code word width.
REQ-003 SHALL provide parameter FILL, default 8'hDF (JMP to last address, halt loop), the value held by every word not written by a load.

Interface
REQ-004 CLK  in  1  sole clock, rising-edge.
REQ-005 RST  in  1  reset, asynchronous, active-high.
REQ-006 PCNT  in  ADDR_W  fetch address from the program counter.
REQ-007 FETCH_EN  in  1  fetch request, sampled on CLK.
REQ-008 MC_CODE  out  DATA_W  registered machine code.
REQ-009 MC_VALID  out  1  MC_CODE holds the word fetched in the previous cycle.
REQ-010 LD_START  in  1  request to clear and reload program memory.
REQ-011 LD_DATA  in  DATA_W  load word.
REQ-012 LD_VALID  in  1  LD_DATA valid.
REQ-013 LD_LAST  in  1  qualifies the final load word.
REQ-014 LD_READY  out  1  block accepts a load word this cycle.
REQ-015 LD_DONE  out  1  one-cycle pulse, load finished.
REQ-016 LD_CNT  out  ADDR_W+1  number of words written by the most recent load.
REQ-017 BUSY  out  1  high in CLEAR and LOAD states.

Function
REQ-018 SHALL implement states IDLE, CLEAR, LOAD; BUSY = (state != IDLE).
REQ-019 IDLE -> CLEAR on rising CLK with LD_START=1; LD_START SHALL be ignored in CLEAR and LOAD.
REQ-020 CLEAR SHALL write FILL to addresses 0..DEPTH-1, one per cycle, ascending; after writing DEPTH-1 -> LOAD with write pointer 0 and LD_CNT 0.
REQ-021 LD_READY SHALL be 1 only in LOAD; a word is accepted on a CLK edge where LD_VALID=1 and LD_READY=1.
REQ-022 Each accepted word SHALL be written at the write pointer; pointer and LD_CNT increment by 1.
REQ-023 Accepted word with LD_LAST=1 -> IDLE, LD_DONE=1 next cycle.
REQ-024 Accepted word at address DEPTH-1 -> IDLE with LD_DONE=1 next cycle regardless of LD_LAST; no wrap, no overwrite of address 0.
REQ-025 LD_VALID=0 in LOAD SHALL stall indefinitely, no write, no state change.
REQ-026 In IDLE, FETCH_EN=1 SHALL register mem[PCNT] into MC_CODE at the edge; MC_VALID=1 in the following cycle; latency 1 cycle.
REQ-027 In IDLE, FETCH_EN=0 SHALL hold MC_CODE and drive MC_VALID=0.
REQ-028 In CLEAR or LOAD, MC_CODE SHALL be FILL and MC_VALID=0 regardless of FETCH_EN.
REQ-029 LD_CNT SHALL hold its final value in IDLE until the next CLEAR entry; max value DEPTH.
REQ-030 LD_DONE SHALL be asserted exactly one cycle per completed load.

Reset
REQ-031 RST=1 SHALL immediately force: state CLEAR, clear pointer 0, MC_CODE=FILL, MC_VALID=0, LD_READY=0, LD_DONE=0, LD_CNT=0, BUSY=1.
REQ-032 After RST release, the block SHALL run CLEAR (DEPTH cycles) then LOAD; all words read FILL if no word loaded.
REQ-033 RST asserted mid-LOAD SHALL abort the load; previously written words SHALL be overwritten by the following CLEAR.

Verification (ADDR_W=4, DATA_W=8, FILL=8'hDF)
REQ-034 Reset, release, count cycles -> BUSY=1 for 16 cycles of CLEAR, LD_READY=1 on cycle 17.
REQ-035 Load 90,4E,D0 with LD_LAST on D0, then fetch PCNT=0,1,2,3 -> MC_CODE 90,4E,D0,DF each one cycle after request, MC_VALID=1; LD_DONE one pulse, LD_CNT=3.
REQ-036 Load 16 words 00..0F without LD_LAST, present 17th word -> LD_DONE after 16th, LD_READY=0, 17th not written, PCNT=0 reads 00, LD_CNT=16.
REQ-037 Toggle LD_VALID 1/0 every cycle during LOAD -> writes only on valid cycles, LD_CNT matches accepted count.
REQ-038 Assert RST after 2 of 5 words, then load single word A1 with LD_LAST -> PCNT=0 reads A1, PCNT=1 reads DF.
REQ-039 Assert LD_START and FETCH_EN in same IDLE cycle -> state CLEAR next, MC_VALID=0, reload completes normally.
